// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Sequences en/Start/Stop, watches for a hung master, returns status.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STOP_HOLD      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_address,
  input  logic [8*NUM_REQ-1:0] req_register,
  input  logic [NUM_REQ-1:0]   req_mode,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 resp_nack,
  output logic                 resp_timeout,
  output logic [7:0]           resp_rdata,
  output logic                 busy,
  output logic                 m_en,
  output logic                 m_start,
  output logic                 m_stop,
  output logic [6:0]           m_address,
  output logic [7:0]           m_register,
  output logic                 m_mode,
  input  logic                 m_done,
  input  logic                 m_ack,
  input  logic [7:0]           m_rdata
);

  localparam int GW = (NUM_REQ > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + STOP_HOLD) + 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TMO_END  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LAUNCH, S_WAIT, S_STOP, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                resp_nack_q, resp_nack_d;
  logic                resp_timeout_q, resp_timeout_d;
  logic [7:0]          resp_rdata_q, resp_rdata_d;
  logic                busy_q, busy_d;
  logic                m_en_q, m_en_d;
  logic                m_start_q, m_start_d;
  logic                m_stop_q, m_stop_d;
  logic [6:0]          m_address_q, m_address_d;
  logic [7:0]          m_register_q, m_register_d;
  logic                m_mode_q, m_mode_d;
  logic                ack_q, ack_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                tmo_q, tmo_d;

  logic [GW-1:0]       win;
  logic [GW:0]         idx;
  logic [6:0]          sel_addr;
  logic [7:0]          sel_reg;
  logic                sel_mode;

  // Round-robin pick: first set req after last_grant, wrapping around.
  always_comb begin
    win = last_grant_q;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_grant_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (req[idx[GW-1:0]]) win = idx[GW-1:0];
    end
  end

  // Select the winning requester's address, register and mode.
  always_comb begin
    sel_addr = '0;
    sel_reg  = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) begin
        sel_addr = req_address[7*i +: 7];
        sel_reg  = req_register[8*i +: 8];
        sel_mode = req_mode[i];
      end
    end
  end

  // Next-state and next-output logic; outputs describe the state entered.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    done_d         = '0;
    resp_nack_d    = resp_nack_q;
    resp_timeout_d = resp_timeout_q;
    resp_rdata_d   = resp_rdata_q;
    busy_d         = busy_q;
    m_en_d         = m_en_q;
    m_start_d      = 1'b0;
    m_stop_d       = m_stop_q;
    m_address_d    = m_address_q;
    m_register_d   = m_register_q;
    m_mode_d       = m_mode_q;
    ack_d          = ack_q;
    rdata_d        = rdata_q;
    tmo_d          = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d      = S_ARB;
          busy_d       = 1'b1;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          last_grant_d = win;
          m_address_d  = sel_addr;
          m_register_d = sel_reg;
          m_mode_d     = sel_mode;
        end
      end
      S_ARB: begin
        state_d   = S_LAUNCH;
        m_en_d    = 1'b1;
        m_start_d = 1'b1;
        m_stop_d  = 1'b0;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (m_done) begin
          state_d  = S_STOP;
          ack_d    = m_ack;
          rdata_d  = m_mode_q ? m_rdata : 8'h00;
          tmo_d    = 1'b0;
          cnt_d    = '0;
          m_en_d   = 1'b0;
          m_stop_d = 1'b1;
        end else if (cnt_q == TMO_END) begin
          state_d  = S_STOP;
          ack_d    = 1'b0;
          rdata_d  = 8'h00;
          tmo_d    = 1'b1;
          cnt_d    = '0;
          m_en_d   = 1'b0;
          m_stop_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_END) begin
          state_d        = S_RESP;
          done_d         = gnt_q;
          resp_nack_d    = ~ack_q | tmo_q;
          resp_timeout_d = tmo_q;
          resp_rdata_d   = rdata_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      last_grant_q   <= LAST_RST;
      gnt_q          <= '0;
      done_q         <= '0;
      resp_nack_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= '0;
      busy_q         <= 1'b0;
      m_en_q         <= 1'b0;
      m_start_q      <= 1'b0;
      m_stop_q       <= 1'b1;
      m_address_q    <= '0;
      m_register_q   <= '0;
      m_mode_q       <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      tmo_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      resp_nack_q    <= resp_nack_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
      busy_q         <= busy_d;
      m_en_q         <= m_en_d;
      m_start_q      <= m_start_d;
      m_stop_q       <= m_stop_d;
      m_address_q    <= m_address_d;
      m_register_q   <= m_register_d;
      m_mode_q       <= m_mode_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      tmo_q          <= tmo_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign resp_nack    = resp_nack_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_rdata   = resp_rdata_q;
  assign busy         = busy_q;
  assign m_en         = m_en_q;
  assign m_start      = m_start_q;
  assign m_stop       = m_stop_q;
  assign m_address    = m_address_q;
  assign m_register   = m_register_q;
  assign m_mode       = m_mode_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: vector table, master model, scoreboard.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_i2c_bus_arbiter;

  localparam int NR   = 4;
  localparam int TMO  = 16;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [7*NR-1:0] req_address;
  logic [8*NR-1:0] req_register;
  logic [NR-1:0] req_mode;
  logic [NR-1:0] gnt;
  logic [NR-1:0] done;
  logic          resp_nack;
  logic          resp_timeout;
  logic [7:0]    resp_rdata;
  logic          busy;
  logic          m_en;
  logic          m_start;
  logic          m_stop;
  logic [6:0]    m_address;
  logic [7:0]    m_register;
  logic          m_mode;
  logic          m_done;
  logic          m_ack;
  logic [7:0]    m_rdata;

  i2c_bus_arbiter #(
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO), .STOP_HOLD(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_address(req_address), .req_register(req_register),
    .req_mode(req_mode), .gnt(gnt), .done(done),
    .resp_nack(resp_nack), .resp_timeout(resp_timeout),
    .resp_rdata(resp_rdata), .busy(busy), .m_en(m_en),
    .m_start(m_start), .m_stop(m_stop), .m_address(m_address),
    .m_register(m_register), .m_mode(m_mode), .m_done(m_done),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mode;
    logic [3:0] drop;
    logic       hold;
    int         delay;
    logic       ack;
    logic [7:0] rdata;
    int         win;
    logic       nack;
    logic       tmo;
    logic [7:0] erd;
  } vec_t;

  typedef struct {
    int         win;
    logic       nack;
    logic       tmo;
    logic [7:0] rd;
  } exp_t;

  vec_t       vecs[11];
  exp_t       sb[$];
  logic [6:0] addr_tab[4];
  logic [7:0] reg_tab[4];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int         n;
    logic       ok;
    logic       gbad;
    logic [3:0] oh;
    exp_t       e;
    exp_t       g;
    oh       = 4'b0001 << v.win;
    req      = v.req;
    req_mode = v.mode;
    e.win    = v.win;
    e.nack   = v.nack;
    e.tmo    = v.tmo;
    e.rd     = v.erd;
    sb.push_back(e);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 10) begin
      @(negedge clk);
      n++;
      if (m_start) ok = 1'b1;
    end
    chk("start_seen", 32'(ok), 1);
    if (!ok) begin
      e = sb.pop_back();
      return;
    end
    chk("start_lat", n, 2);
    chk("gnt", 32'(gnt), 32'(oh));
    chk("m_address", 32'(m_address), 32'(addr_tab[v.win]));
    chk("m_register", 32'(m_register), 32'(reg_tab[v.win]));
    chk("m_mode", 32'(m_mode), 32'(v.mode[v.win]));
    chk("launch_en_stop", {m_en, m_stop, busy}, 3'b101);
    @(negedge clk);
    chk("start_pulse", {m_start, m_en}, 2'b01);
    req = req & ~v.drop;
    if (v.delay < 0) begin
      n = 1;
      while (m_en && n < 100) begin
        @(negedge clk);
        if (m_en) n++;
      end
      chk("wait_cycles", n, TMO);
    end else begin
      repeat (v.delay - 1) @(negedge clk);
      m_done  = 1'b1;
      m_ack   = v.ack;
      m_rdata = v.rdata;
      chk("wait_en", 32'(m_en), 1);
      @(negedge clk);
      m_done  = 1'b0;
      m_ack   = 1'b0;
      m_rdata = 8'h00;
    end
    chk("stop_en", {m_en, m_stop}, 2'b01);
    n    = 0;
    gbad = 1'b0;
    while (done == 4'b0 && n < 100) begin
      if (gnt !== oh || m_stop !== 1'b1) gbad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("stop_hold", n, HOLD);
    chk("gnt_stable", {gbad, gnt}, {1'b0, oh});
    chk("done", 32'(done), 32'(oh));
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: got done with empty queue");
    end else begin
      g = sb.pop_front();
      chk("done_win", 32'(done), 32'(4'b0001 << g.win));
      chk("resp_nack", 32'(resp_nack), 32'(g.nack));
      chk("resp_timeout", 32'(resp_timeout), 32'(g.tmo));
      chk("resp_rdata", 32'(resp_rdata), 32'(g.rd));
    end
    if (!v.hold) req = req & ~oh;
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("idle", {busy, gnt}, 5'b0);
    chk("resp_keep", {resp_nack, resp_timeout, resp_rdata},
        {v.nack, v.tmo, v.erd});
  endtask

  initial begin
    int   n;
    logic bad;
    addr_tab = '{7'h70, 7'h21, 7'h4C, 7'h3A};
    reg_tab  = '{8'hB2, 8'h10, 8'h7E, 8'hC5};
    for (int i = 0; i < NR; i++) begin
      req_address[7*i +: 7]  = addr_tab[i];
      req_register[8*i +: 8] = reg_tab[i];
    end
    //          req      mode     drop     hold dly ack rdata  win nack tmo erd
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 10, 1'b1, 8'hFF, 0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1,  3, 1'b1, 8'hFF, 1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1,  3, 1'b1, 8'hFF, 2, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1,  3, 1'b1, 8'hFF, 3, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0,  3, 1'b1, 8'hFF, 0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0,  5, 1'b0, 8'h5A, 2, 1'b1, 1'b0, 8'h5A};
    vecs[6]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, -1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 8'h00};
    vecs[7]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 16, 1'b1, 8'hC3, 1, 1'b0, 1'b0, 8'hC3};
    vecs[8]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0,  4, 1'b1, 8'h77, 3, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{4'b0101, 4'b0101, 4'b0000, 1'b0,  2, 1'b1, 8'h3C, 0, 1'b0, 1'b0, 8'h3C};
    vecs[10] = '{4'b0110, 4'b0000, 4'b0000, 1'b0,  3, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h00};

    reset    = 1'b0;
    req      = '0;
    req_mode = '0;
    m_done   = 1'b0;
    m_ack    = 1'b0;
    m_rdata  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {gnt, done, busy, m_en, m_start, m_stop},
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("rst_m", {m_address, m_register, m_mode}, 0);
    chk("rst_resp", {resp_nack, resp_timeout, resp_rdata}, 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    req      = 4'b0001;
    req_mode = 4'b0000;
    n = 0;
    while (!m_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_seq_start", 32'(m_start), 1);
    repeat (5) @(negedge clk);
    chk("rst_seq_wait", {m_en, m_stop, busy}, 3'b101);
    reset = 1'b0;
    #1;
    chk("rst_async", {m_en, m_stop, busy, gnt, done},
        {1'b0, 1'b1, 1'b0, 4'b0, 4'b0});
    req = 4'b0110;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 4'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("rst_no_done", 32'(bad), 0);
    reset = 1'b1;
    run_txn(vecs[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master between NUM_REQ on-chip requesters, e.g. the sensor-read and config-write engines.
- Arbitrates round-robin and latches the winner's address, register and mode.
- Sequences the master's en/Start/Stop controls through one transaction, with a watchdog timeout.
- Returns per-requester completion and status.
- Sits between the requesters and the I2C master instance.

Parameters:
- NUM_REQ, 4: number of requesters (grant index width 2; legal values 2..4).
- TIMEOUT_CYCLES, 1024: clk cycles in WAIT before the transaction is aborted.
- STOP_HOLD, 4: clk cycles Stop is held, with en low, between transactions.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its done.
- req_address  in  7*NUM_REQ  7-bit slave address per requester; requester i occupies [7i+6:7i].
- req_register  in  8*NUM_REQ  register byte per requester.
- req_mode  in  NUM_REQ  0 = write, 1 = read.
- gnt  out  NUM_REQ  one-hot grant, high from ARB through RESP.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_nack  out  1  last transaction was not acknowledged, or timed out.
- resp_timeout  out  1  last transaction hit TIMEOUT_CYCLES.
- resp_rdata  out  8  read data from the last transaction.
- busy  out  1  state != IDLE.
- m_en  out  1  master enable.
- m_start  out  1  master Start.
- m_stop  out  1  master Stop.
- m_address  out  7  latched address.
- m_register  out  8  latched register byte.
- m_mode  out  1  latched mode.
- m_done  in  1  one-cycle pulse from the master at end of transaction.
- m_ack  in  1  slave acknowledged all bytes; valid with m_done.
- m_rdata  in  8  master read data; valid with m_done.

Behaviour:
- All outputs are registered.
- Reset (reset low, asynchronous) forces:
  - state = IDLE; gnt, done, busy, m_en, m_start = 0; m_stop = 1;
  - m_address, m_register, m_mode, resp_* = 0;
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction aborts immediately: no done pulse, no status update.
- IDLE: m_en = 0, m_stop = 1. If any req bit is high, go to ARB next cycle.
- ARB (1 cycle):
  - Winner is the first set req bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch the winner's address, register and mode into m_*; set gnt one-hot and last_grant = winner; go to LAUNCH.
- LAUNCH (1 cycle): m_en = 1, m_start = 1, m_stop = 0; clear the timer; go to WAIT.
  - m_start is high exactly 2 cycles after the first IDLE cycle in which req was sampled high.
- WAIT: m_en = 1, m_start = 0, m_stop = 0; timer increments each cycle.
  - On m_done: latch m_ack and m_rdata, clear the timeout flag, go to STOP.
  - Else when the timer reaches TIMEOUT_CYCLES-1: set the timeout flag and ack_latched = 0, go to STOP.
  - m_done on the same cycle as the timer reaching its terminal count: m_done wins, not a timeout.
- STOP: m_stop = 1, m_en = 0 for exactly STOP_HOLD cycles, then RESP.
- RESP (1 cycle):
  - done[winner] = 1.
  - resp_nack = ~ack_latched | timeout; resp_timeout = timeout; resp_rdata = latched data (0 for a write or a timeout).
  - gnt clears on exit; go to IDLE.
  - resp_* hold until the next RESP.
- m_done outside WAIT is ignored.
- Requests are not re-sampled during a transaction. A granted requester dropping req before done does not abort: the transaction completes and done still pulses.
- Minimum turnaround, req seen to done: 1 (IDLE) + 1 (ARB) + 1 (LAUNCH) + WAIT length + STOP_HOLD + 1 (RESP).
- After RESP, at least one IDLE cycle occurs before the next ARB.
- A requester still holding req after its done is served again only after every other pending requester has been served.

Test Plan:
- Single request, success: req = 4'b0001, addr 7'h70, reg 8'hB2, mode 0; m_done with m_ack = 1 ten cycles after m_start.
  -> m_start one cycle high; m_address = 7'h70, m_register = 8'hB2.
  -> m_stop high STOP_HOLD = 4 cycles; done[0] one cycle; resp_nack = 0.
- Round-robin: req = 4'b1111 held, each transaction acked.
  -> grant order 0, 1, 2, 3, 0; gnt is always one-hot; exactly one done per transaction.
- NACK read: req[2] with mode 1; m_done with m_ack = 0, m_rdata = 8'h5A.
  -> done[2] pulses; resp_nack = 1, resp_timeout = 0, resp_rdata = 8'h5A.
- Timeout: TIMEOUT_CYCLES = 16; m_done never asserted.
  -> exactly 16 WAIT cycles, then m_stop = 1 and m_en = 0.
  -> resp_timeout = 1, resp_nack = 1, resp_rdata = 0; done pulses.
  -> Edge case: m_done coincident with the 16th WAIT cycle gives resp_timeout = 0.
- Reset mid-WAIT: assert reset low 5 cycles into WAIT.
  -> same cycle: m_en = 0, m_stop = 1, gnt = 0, busy = 0; no done pulse.
  -> after release with req = 4'b0110: requester 1 is granted first.
- Request drop: req[3] deasserted during WAIT.
  -> transaction still completes; done[3] pulses; the next ARB skips requester 3.
